// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and the default divider.
// The PARITY state and parity helper exist only when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int   UART_DATA_BITS        = 8;
   localparam logic UART_IDLE_LEVEL       = 1'b1;
   localparam int   UART_DEFAULT_BAUD_DIV = 868;
   localparam int   UART_BAUD_CNT_W       = 16;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_e;

   function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] data);
      return ^data;
   endfunction
`else
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd4
   } uart_state_e;
`endif

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous transmit FIFO: power-of-two depth with natural pointer wrap, occupancy
// count and full/empty flags. A push into a full FIFO is taken only together with a pop.
module uart_tx_fifo #(
   parameter int  DEPTH  = 8,
   parameter int  DATA_W = 8,
   localparam int PTR_W  = $clog2(DEPTH),
   localparam int CNT_W  = PTR_W + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   input  logic              pop_i,
   output logic              accept_o,
   output logic [DATA_W-1:0] head_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              pop_ok;

   assign full_o   = (count_q == CNT_W'(DEPTH));
   assign empty_o  = (count_q == '0);
   assign pop_ok   = pop_i && !empty_o;
   assign accept_o = push_i && (!full_o || pop_ok);
   assign head_o   = mem_q[rd_ptr_q];
   assign count_o  = count_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (accept_o) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_ok)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({accept_o, pop_ok})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; an entry is only read after the count shows it written.
   always_ff @(posedge clk) begin
      if (accept_o && !rst) mem_q[wr_ptr_q] <= push_data_i;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a byte FIFO fed by an MMIO write strobe; 8N1 frames by default,
// 8E1 (even parity bit after the data) when UART_TX_PARITY_EN is defined.
module uart_tx
   import uart_pkg::*;
#(
   parameter int  BAUD_DIV   = UART_DEFAULT_BAUD_DIV,
   parameter int  FIFO_DEPTH = 8,
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [UART_DATA_BITS-1:0] wr_data,
   output logic                      fifo_full,
   output logic [CNT_W-1:0]          fifo_count,
   output logic                      tx_busy,
   output logic                      overflow,
   output logic                      txd
);

   localparam logic [UART_BAUD_CNT_W-1:0] BAUD_RELOAD = UART_BAUD_CNT_W'(BAUD_DIV - 1);

   uart_state_e                state_q, state_d;
   logic [UART_BAUD_CNT_W-1:0] baud_cnt_q, baud_cnt_d;
   logic [2:0]                 bit_idx_q, bit_idx_d;
   logic [UART_DATA_BITS-1:0]  shift_q, shift_d;
   logic                       txd_q, txd_d;
   logic                       overflow_q, overflow_d;
`ifdef UART_TX_PARITY_EN
   logic                       parity_q, parity_d;
`endif

   logic                      start_frame;
   logic                      bit_end;
   logic                      fifo_accept;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_head;

   uart_tx_fifo #(
      .DEPTH  (FIFO_DEPTH),
      .DATA_W (UART_DATA_BITS)
   ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (wr_en),
      .push_data_i (wr_data),
      .pop_i       (start_frame),
      .accept_o    (fifo_accept),
      .head_o      (fifo_head),
      .count_o     (fifo_count),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty)
   );

   assign bit_end = (baud_cnt_q == '0);

   always_comb begin
      // NOTE: every next-state signal takes its hold value first, so no path through the case infers a latch.
      state_d     = state_q;
      baud_cnt_d  = baud_cnt_q;
      bit_idx_d   = bit_idx_q;
      shift_d     = shift_q;
      txd_d       = txd_q;
`ifdef UART_TX_PARITY_EN
      parity_d    = parity_q;
`endif
      start_frame = 1'b0;

      if (state_q != ST_IDLE) begin
         baud_cnt_d = bit_end ? BAUD_RELOAD : baud_cnt_q - UART_BAUD_CNT_W'(1);
      end

      case (state_q)
         ST_IDLE: begin
            start_frame = !fifo_empty;
         end
         ST_START: begin
            if (bit_end) begin
               state_d = ST_DATA;
               txd_d   = shift_q[0];
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                  state_d = ST_PARITY;
                  txd_d   = parity_q;
`else
                  state_d = ST_STOP;
                  txd_d   = UART_IDLE_LEVEL;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  txd_d   = shift_q[1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d = ST_STOP;
               txd_d   = UART_IDLE_LEVEL;
            end
         end
`endif
         ST_STOP: begin
            // A queued byte starts its frame straight out of the stop bit, with no idle gap.
            if (bit_end) begin
               if (!fifo_empty) begin
                  start_frame = 1'b1;
               end else begin
                  state_d = ST_IDLE;
                  txd_d   = UART_IDLE_LEVEL;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            txd_d   = UART_IDLE_LEVEL;
         end
      endcase

      if (start_frame) begin
         state_d    = ST_START;
         txd_d      = ~UART_IDLE_LEVEL;
         shift_d    = fifo_head;
         baud_cnt_d = BAUD_RELOAD;
         bit_idx_d  = '0;
`ifdef UART_TX_PARITY_EN
         parity_d   = even_parity(fifo_head);
`endif
      end
   end

   assign overflow_d = overflow_q | (wr_en & ~fifo_accept);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         baud_cnt_q <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         txd_q      <= UART_IDLE_LEVEL;
         overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q   <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         txd_q      <= txd_d;
         overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
         parity_q   <= parity_d;
`endif
      end
   end

   assign txd      = txd_q;
   assign overflow = overflow_q;
   assign tx_busy  = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: a queue/timer reference model predicts every output each
// cycle, and an independent line decoder checks frame contents; directed cases plus random traffic.
module tb_uart_tx;

   localparam int BAUD  = 4;
   localparam int DEPTH = 8;
`ifdef UART_TX_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * BAUD;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       fifo_full;
   logic [3:0] fifo_count;
   logic       tx_busy;
   logic       overflow;
   logic       txd;

   uart_tx #(
      .BAUD_DIV   (BAUD),
      .FIFO_DEPTH (DEPTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (wr_en),
      .wr_data    (wr_data),
      .fifo_full  (fifo_full),
      .fifo_count (fifo_count),
      .tx_busy    (tx_busy),
      .overflow   (overflow),
      .txd        (txd)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model: byte queue + time into current frame ----------------
   logic [7:0] m_q[$];
   logic [7:0] sent_q[$];
   logic [7:0] m_cur = 8'h00;
   bit         m_active = 0;
   int         m_t = 0;
   bit         m_ovf = 0;
   bit         m_pop, m_push, m_end;
   bit         mon_reset = 1;

   function automatic logic exp_txd();
      int b;
      if (!m_active) return 1'b1;
      b = m_t / BAUD;
      if (b == 0) return 1'b0;
      if (b <= 8) return m_cur[b-1];
`ifdef UART_TX_PARITY_EN
      if (b == 9) return ^m_cur;
`endif
      return 1'b1;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_q.delete();
         sent_q.delete();
         m_active  = 0;
         m_t       = 0;
         m_ovf     = 0;
         mon_reset = 1;
      end else begin
         m_end  = m_active && (m_t == FRAME_CYC - 1);
         m_pop  = (m_q.size() != 0) && (!m_active || m_end);
         m_push = wr_en && ((m_q.size() < DEPTH) || m_pop);
         if (wr_en && !m_push) m_ovf = 1;
         if (m_pop) begin
            m_cur    = m_q.pop_front();
            sent_q.push_back(m_cur);
            m_active = 1;
            m_t      = 0;
         end else if (m_end) begin
            m_active = 0;
         end else if (m_active) begin
            m_t++;
         end
         if (m_push) m_q.push_back(wr_data);
      end
   end

   // ---------------- per-cycle output checks and independent line decoder ----------------
   int         cyc = 0;
   bit         mon_active = 0;
   int         mon_p = 0;
   int         mon_b;
   logic [7:0] mon_byte = 8'h00;
   logic       mon_par = 1'b0;
   logic       last_par = 1'b0;
   logic [7:0] rx_log[$];
   int         start_cyc[$];

   always @(negedge clk) begin
      cyc++;
      check("txd", txd, exp_txd());
      check("fifo_count", fifo_count, m_q.size());
      check("fifo_full", fifo_full, m_q.size() == DEPTH);
      check("tx_busy", tx_busy, m_active || (m_q.size() != 0));
      check("overflow", overflow, m_ovf);

      if (mon_reset) begin
         mon_active = 0;
         mon_reset  = 0;
      end else if (!mon_active) begin
         if (txd === 1'b0) begin
            mon_active = 1;
            mon_p      = 0;
            start_cyc.push_back(cyc);
         end
      end else begin
         mon_p++;
      end

      if (mon_active && (mon_p % BAUD) == BAUD / 2) begin
         mon_b = mon_p / BAUD;
         if (mon_b >= 1 && mon_b <= 8) mon_byte[mon_b-1] = txd;
`ifdef UART_TX_PARITY_EN
         if (mon_b == 9) mon_par = txd;
`endif
         if (mon_b == FRAME_BITS - 1) begin
            check("stop_bit", txd, 1'b1);
`ifdef UART_TX_PARITY_EN
            check("parity_rule", mon_par, ^mon_byte);
            last_par = mon_par;
`endif
            check("frame_expected", sent_q.size() != 0, 1'b1);
            if (sent_q.size() != 0) check("frame_byte", mon_byte, sent_q.pop_front());
            rx_log.push_back(mon_byte);
         end
      end
      if (mon_active && mon_p == FRAME_CYC - 1) mon_active = 0;
   end

   // ---------------- stimulus helpers ----------------
   task automatic write_byte(input logic [7:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (tx_busy !== 1'b0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", tx_busy, 1'b0);
   endtask

   task automatic wait_frame_pos(input int pos);
      int n = 0;
      while (!(m_active && m_t == pos) && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("frame_pos_timeout", n < 500, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int rate;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_txd", txd, 1'b1);
      check("rst_count", fifo_count, 0);
      check("rst_busy", tx_busy, 1'b0);
      check("rst_ovf", overflow, 1'b0);

      // single byte from idle: start bit one cycle after the write cycle
      rx_log.delete();
      write_byte(8'h55);
      @(negedge clk);
      check("s55_start", txd, 1'b0);
      repeat (FRAME_CYC - 1) @(negedge clk);
      check("s55_stop", txd, 1'b1);
      check("s55_busy_end", tx_busy, 1'b1);
      @(negedge clk);
      check("s55_idle", tx_busy, 1'b0);
      check("s55_count", rx_log.size(), 1);
      if (rx_log.size() == 1) check("s55_byte", rx_log[0], 8'h55);

`ifdef UART_TX_PARITY_EN
      write_byte(8'h07);
      wait_idle();
      check("par_07", last_par, 1'b1);
      write_byte(8'h03);
      wait_idle();
      check("par_03", last_par, 1'b0);
`endif

      // ten back-to-back writes: the tenth is dropped
      rx_log.delete();
      for (int i = 0; i < 10; i++) begin
         wr_en   = 1'b1;
         wr_data = 8'(i);
         @(negedge clk);
         if (i == 8) check("burst_full", fifo_full, 1'b1);
      end
      wr_en = 1'b0;
      check("burst_ovf", overflow, 1'b1);
      wait_idle();
      check("burst_rx_count", rx_log.size(), 9);
      for (int i = 0; i < 9; i++) begin
         if (rx_log.size() > i) check("burst_rx_order", rx_log[i], 8'(i));
      end
      check("burst_ovf_sticky", overflow, 1'b1);
      pulse_reset();
      check("burst_ovf_clear", overflow, 1'b0);

      // two bytes: frames must be contiguous
      rx_log.delete();
      start_cyc.delete();
      write_byte(8'hA5);
      write_byte(8'h3C);
      wait_idle();
      check("b2b_frames", start_cyc.size(), 2);
      if (start_cyc.size() == 2) check("b2b_gap", start_cyc[1] - start_cyc[0], FRAME_CYC);
      if (rx_log.size() == 2) begin
         check("b2b_first", rx_log[0], 8'hA5);
         check("b2b_second", rx_log[1], 8'h3C);
      end

      // reset in the middle of a 0xFF frame with three bytes queued
      write_byte(8'hFF);
      write_byte(8'h11);
      write_byte(8'h22);
      write_byte(8'h33);
      wait_frame_pos(15);
      check("mid_queued", fifo_count, 3);
      pulse_reset();
      check("mid_txd", txd, 1'b1);
      check("mid_count", fifo_count, 0);
      check("mid_busy", tx_busy, 1'b0);
      check("mid_ovf", overflow, 1'b0);

      // write into a full FIFO on the same cycle the stop bit ends
      rx_log.delete();
      for (int i = 0; i < 9; i++) write_byte(8'h80 + 8'(i));
      check("full_pre", fifo_full, 1'b1);
      wait_frame_pos(FRAME_CYC - 1);
      check("full_at_stop", fifo_full, 1'b1);
      write_byte(8'h5A);
      check("full_swap_count", fifo_count, 8);
      check("full_swap_ovf", overflow, 1'b0);
      wait_idle();
      check("full_rx_count", rx_log.size(), 10);
      if (rx_log.size() == 10) check("full_rx_last", rx_log[9], 8'h5A);

      // random traffic with occasional resets
      for (int blk = 0; blk < 6; blk++) begin
         rate = (blk % 3 == 0) ? 3 : ((blk % 3 == 1) ? 12 : 45);
         for (int n = 0; n < 500; n++) begin
            wr_en   = ($urandom_range(0, 99) < rate);
            wr_data = 8'($urandom);
            rst     = ($urandom_range(0, 999) == 0);
            @(negedge clk);
         end
      end
      wr_en = 1'b0;
      rst   = 1'b0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868: clocks per serial bit (100 MHz / 115200); legal range 2..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8: transmit FIFO entries; power of two, 2..64.
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port wr_en, input, 1: MMIO byte write strobe from the CPU store path, sampled each cycle.
REQ-006 SHALL have port wr_data, input, 8: the byte to transmit; valid when wr_en=1.
REQ-007 SHALL have port fifo_full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-008 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1: number of queued bytes.
REQ-009 SHALL have port tx_busy, output, 1: a frame is in progress or the FIFO is non-empty.
REQ-010 SHALL have port overflow, output, 1: sticky; a write was dropped.
REQ-011 SHALL have port txd, output, 1: serial line, idle high; registered.

Function
REQ-012 SHALL accept a write when wr_en=1 and (fifo_full=0 or a pop occurs in the same cycle).
REQ-013 SHALL drop a write when wr_en=1, fifo_full=1 and no pop occurs; overflow is set to 1 and stays 1 until reset.
REQ-014 SHALL apply a simultaneous push and pop as a single operation: fifo_count unchanged, order preserved.
REQ-015 SHALL use the FSM states IDLE, START, DATA, PARITY and STOP.
REQ-016 In IDLE with FIFO non-empty, SHALL pop the head entry into a shift register and enter START on that edge.
REQ-017 SHALL drive txd=0 from that same edge, so a byte written into an empty FIFO in IDLE appears as a start bit one cycle after the write cycle.
REQ-018 SHALL hold each bit on txd for exactly BAUD_DIV cycles, timed by a down-counter reloaded on every bit boundary.
REQ-019 SHALL step through START -> DATA (8 bits, LSB first) -> [PARITY] -> STOP (txd=1) -> IDLE.
REQ-020 SHALL use a 3-bit bit-index counter in DATA that wraps 7->0 on the exit to the next state.
REQ-021 When STOP ends and the FIFO is non-empty, SHALL pop and enter START directly, giving back-to-back frames with no idle gap.
REQ-022 SHALL assert tx_busy when state!=IDLE or fifo_count!=0.

Reset
REQ-023 On rst=1, SHALL on that edge force: state=IDLE, txd=1, fifo_count=0 (contents discarded), overflow=0, baud counter=0 and bit index=0.
REQ-024 On rst=1, SHALL ignore any write in the same cycle; reset mid-frame truncates the frame and txd is high from the next cycle.

Configuration
REQ-025 With UART_TX_PARITY_EN defined, SHALL insert a PARITY bit (even parity: XOR of the 8 data bits) after DATA; a frame is 11 bits.
REQ-026 With UART_TX_PARITY_EN undefined, SHALL go from DATA directly to STOP; a frame is 10 bits, and the PARITY state and logic are not present.

Structure
REQ-027 SHALL place in shared package uart_pkg: the FSM state enum, UART_DATA_BITS=8, UART_IDLE_LEVEL=1'b1, and the default divider constant.
REQ-028 SHALL implement the FIFO as sub-module uart_tx_fifo: synchronous, pointer wrap modulo FIFO_DEPTH, with count, full and empty outputs.

Verification (BAUD_DIV=4, FIFO_DEPTH=8, parity off unless stated)
REQ-029 SHALL cover: write 0x55 from idle -> txd low one cycle later, then 0,1,0,1,0,1,0,1,0,1 at 4 cycles each (40 cycles), then tx_busy=0.
REQ-030 SHALL cover: with UART_TX_PARITY_EN, write 0x07 -> parity bit 1, frame 44 cycles; write 0x03 -> parity bit 0.
REQ-031 SHALL cover: 10 writes on consecutive cycles from idle (0x00..0x09) -> 0x00..0x08 transmitted in order, 0x09 dropped, overflow=1, fifo_full=1 after the 9th write.
REQ-032 SHALL cover: write 0xA5 then 0x3C -> frames contiguous; the stop bit of the first frame is immediately followed by the start bit of the second.
REQ-033 SHALL cover: rst=1 at cycle 15 of a 0xFF frame with 3 bytes queued -> next cycle txd=1, fifo_count=0, tx_busy=0, overflow=0.
REQ-034 SHALL cover: with fifo_full=1 and a pop occurring at STOP end, wr_en=1 in the same cycle -> write accepted, fifo_count stays 8, overflow stays 0.
